// File: rtl/pipe_sub_32bit.sv
// Pipelined subtractor: diff = a - b - bin, one SLICE-bit slice per stage.
// Define SUB_FLAGS_EN to add the registered zero and ovf flag outputs.
module pipe_sub_32bit #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SUB_FLAGS_EN
   ,
   output logic             zero,
   output logic             ovf
`endif
);

   localparam int N = WIDTH / SLICE;

   logic             vld [N];
   logic             brw [N];
   logic [WIDTH-1:0] opa [N];
   logic [WIDTH-1:0] opb [N];
   logic [WIDTH-1:0] res [N];

   logic             src_v  [N];
   logic             src_bw [N];
   logic [WIDTH-1:0] src_a  [N];
   logic [WIDTH-1:0] src_b  [N];
   logic [WIDTH-1:0] src_r  [N];
   logic [SLICE:0]   sum    [N];
   logic [WIDTH-1:0] nxt_r  [N];
   logic             nxt_bw [N];

   logic             advance;

   assign out_valid = vld[N-1];
   assign diff      = res[N-1];
   assign bout      = brw[N-1];
   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;

   // Borrow is kept in true polarity so reset leaves bout = 0;
   // each slice adds with carry = ~borrow.
   always_comb begin
      src_v[0]  = in_valid;
      src_bw[0] = bin;
      src_a[0]  = a;
      src_b[0]  = b;
      src_r[0]  = '0;
      for (int k = 1; k < N; k++) begin
         src_v[k]  = vld[k-1];
         src_bw[k] = brw[k-1];
         src_a[k]  = opa[k-1];
         src_b[k]  = opb[k-1];
         src_r[k]  = res[k-1];
      end
      for (int k = 0; k < N; k++) begin
         sum[k] = {1'b0, src_a[k][k*SLICE +: SLICE]}
                + {1'b0, ~src_b[k][k*SLICE +: SLICE]}
                + {{SLICE{1'b0}}, ~src_bw[k]};
         nxt_r[k] = src_r[k];
         nxt_r[k][k*SLICE +: SLICE] = sum[k][SLICE-1:0];
         nxt_bw[k] = ~sum[k][SLICE];
      end
   end

   // Data registers only load behind a valid token; bubbles leave them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N; k++) begin
            vld[k] <= 1'b0;
            brw[k] <= 1'b0;
            opa[k] <= '0;
            opb[k] <= '0;
            res[k] <= '0;
         end
`ifdef SUB_FLAGS_EN
         zero <= 1'b0;
         ovf  <= 1'b0;
`endif
      end else if (advance) begin
         for (int k = 0; k < N; k++) begin
            vld[k] <= src_v[k];
            if (src_v[k]) begin
               brw[k] <= nxt_bw[k];
               opa[k] <= src_a[k];
               opb[k] <= src_b[k];
               res[k] <= nxt_r[k];
            end
         end
`ifdef SUB_FLAGS_EN
         if (src_v[N-1]) begin
            zero <= (nxt_r[N-1] == '0);
            ovf  <= (src_a[N-1][WIDTH-1] != src_b[N-1][WIDTH-1])
                 && (nxt_r[N-1][WIDTH-1] != src_a[N-1][WIDTH-1]);
         end
`endif
      end
   end

endmodule

// File: tb/tb_pipe_sub_32bit.sv
// Bench for pipe_sub_32bit: vector table, random stream, stall and reset.
// Results are checked by a scoreboard queue at the output handshake.
module tb_pipe_sub_32bit;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        bin;
      logic [31:0] d;
      logic        bo;
      logic        z;
      logic        o;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic        bo;
      logic        z;
      logic        o;
      int          t;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;
   logic        bout;
`ifdef SUB_FLAGS_EN
   logic        zero;
   logic        ovf;
`endif

   pipe_sub_32bit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout)
`ifdef SUB_FLAGS_EN
      ,
      .zero      (zero),
      .ovf       (ovf)
`endif
   );

   int   tests;
   int   fails;
   int   cyc;
   int   npush;
   int   npop;
   bit   push_en;
   bit   lat_chk;
   bit   rand_rdy;
   exp_t sbq [$];
   vec_t tbl [12];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   always @(posedge clk) cyc <= cyc + 1;

   always begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                  input logic bi);
      logic [32:0] r;
      exp_t e;
      r    = {1'b0, x} - {1'b0, y} - {32'b0, bi};
      e.d  = r[31:0];
      e.bo = r[32];
      e.z  = (r[31:0] == 32'h0);
      e.o  = (x[31] != y[31]) && (r[31] != x[31]);
      e.t  = 0;
      return e;
   endfunction

   // Output side: pop and compare on each transfer-out.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         tests++;
         if (sbq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_result: got diff=%h bout=%b, want none",
                     diff, bout);
         end else begin
            exp_t e;
            logic ok;
            e  = sbq.pop_front();
            npop++;
            ok = (diff === e.d) && (bout === e.bo);
`ifdef SUB_FLAGS_EN
            ok = ok && (zero === e.z) && (ovf === e.o);
`endif
            if (!ok) begin
               fails++;
               $display("FAIL result_%0d: got diff=%h bout=%b, want diff=%h bout=%b",
                        npop, diff, bout, e.d, e.bo);
            end
`ifdef SUB_FLAGS_EN
            if (!ok)
               $display("FAIL flags_%0d: got z=%b o=%b, want z=%b o=%b",
                        npop, zero, ovf, e.z, e.o);
`endif
            if (lat_chk) begin
               tests++;
               if (cyc - e.t != 4) begin
                  fails++;
                  $display("FAIL latency_%0d: got %0d want 4", npop, cyc - e.t);
               end
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the transfer edge.
   task automatic drive(input logic [31:0] ta, input logic [31:0] tb,
                        input logic tbin, input exp_t e);
      int n;
      n        = 0;
      a        = ta;
      b        = tb;
      bin      = tbin;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: got in_ready=0 want 1");
      end else if (push_en) begin
         e.t = cyc;
         sbq.push_back(e);
         npush++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drive_vec(input vec_t v);
      exp_t e;
      e.d  = v.d;
      e.bo = v.bo;
      e.z  = v.z;
      e.o  = v.o;
      e.t  = 0;
      drive(v.a, v.b, v.bin, e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", 32'(sbq.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [31:0] sd;
      logic        sb;
      tests    = 0;
      fails    = 0;
      cyc      = 0;
      npush    = 0;
      npop     = 0;
      push_en  = 1'b1;
      lat_chk  = 1'b0;
      rand_rdy = 1'b0;
      rst      = 1'b1;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      bin      = 1'b0;
      out_ready = 1'b1;

      tbl[0]  = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{32'h01000000, 32'h00000001, 1'b0, 32'h00FFFFFF, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{32'h00010000, 32'h0000FFFF, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};

      idle(2);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_diff", diff, 32'd0);
      chk("reset_bout", {31'b0, bout}, 32'd0);
      chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef SUB_FLAGS_EN
      chk("reset_flags", {30'b0, zero, ovf}, 32'd0);
`endif
      @(posedge clk);
      #1;

      // Single transaction, then the table back-to-back.
      lat_chk = 1'b1;
      drive_vec(tbl[0]);
      drain();
      for (int i = 0; i < 12; i++) drive_vec(tbl[i]);
      drain();
      lat_chk = 1'b0;

      // Random operands with random gaps and random out_ready.
      rand_rdy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         logic        rbi;
         ra  = $urandom;
         rb  = (i % 4 == 0) ? ra : $urandom;
         rbi = 1'($urandom_range(0, 1));
         drive(ra, rb, rbi, model(ra, rb, rbi));
         idle($urandom_range(0, 2));
      end
      rand_rdy  = 1'b0;
      out_ready = 1'b1;
      drain();

      // Backpressure: fill all four stages, then hold for 5 cycles.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) drive_vec(tbl[i]);
      @(negedge clk);
      sd = diff;
      sb = bout;
      chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_first_diff", sd, tbl[0].d);
      for (int i = 0; i < 5; i++) begin
         chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
         chk("stall_diff", diff, tbl[0].d);
         chk("stall_bout", {31'b0, bout}, {31'b0, sb});
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();

      // Reset with three transactions in flight.
      push_en = 1'b0;
      for (int i = 4; i < 7; i++) drive_vec(tbl[i]);
      rst = 1'b1;
      #1;
      chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_mid_diff", diff, 32'd0);
      chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      push_en = 1'b1;
      idle(8);
      lat_chk = 1'b1;
      drive_vec(tbl[9]);
      drain();
      lat_chk = 1'b0;

      chk("push_pop_count", 32'(npop), 32'(npush));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
